// File: rtl/sync_bus_pkg.sv
// Shared constants and helpers for the sync_bus channel synchronizer.
// Counter-width helper is evaluated at elaboration time only.
package sync_bus_pkg;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int cnt_width(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_bus_ch.sv
// One channel: DEPTH-flop synchronizer, FILTER-sample deglitch, registered level and strobes.
// Latency DEPTH+FILTER edges from capture to level; no backpressure, free-running.
module sync_bus_ch
  import sync_bus_pkg::*;
#(
  parameter int   DEPTH     = 2,
  parameter int   FILTER    = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change,
  output logic change_nxt
);

  localparam int            CW       = cnt_width(FILTER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  // Synchronizer flops must stay distinct and un-retimed.
  (* keep = "true", async_reg = "true" *) logic [DEPTH-1:0] chain_q;
  logic [DEPTH-1:0] chain_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             change_q, change_d;
  logic             sync;

  assign sync = chain_q[0];

  always_comb begin
    chain_d = {sig_in, chain_q[DEPTH-1:1]};
    level_d = level_q;
    cnt_d   = '0;
    // A differing sample is accepted only once it has been seen FILTER times in a row.
    if (sync != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    rise_d   = level_d & ~level_q;
    fall_d   = ~level_d & level_q;
    change_d = level_d ^ level_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      chain_q  <= {DEPTH{RESET_VAL}};
      cnt_q    <= '0;
      level_q  <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      change_q <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign change     = change_q;
  assign change_nxt = change_d;

endmodule

// File: rtl/sync_bus.sv
// WIDTH independent synchronizer/deglitch channels plus a registered any-change flag.
// Latency DEPTH+FILTER edges; no backpressure, every output is a flop.
module sync_bus
  import sync_bus_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter int               FILTER    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] change,
  output logic             change_any
);

  logic [WIDTH-1:0] change_nxt;
  logic             change_any_q, change_any_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_bus_ch #(
      .DEPTH     (DEPTH),
      .FILTER    (FILTER),
      .RESET_VAL (RESET_VAL[i])
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .sig_in     (sig_in[i]),
      .level      (level[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .change     (change[i]),
      .change_nxt (change_nxt[i])
    );
  end

  // Reduced from next-state so the flag lands in the same cycle as the strobes.
  always_comb begin
    change_any_d = |change_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) change_any_q <= 1'b0;
    else       change_any_q <= change_any_d;
  end

  assign change_any = change_any_q;

endmodule

// File: tb/tb_sync_bus.sv
// Bench for sync_bus: four parameterisations, a vector table, directed sequences and a run-length reference model.
module tb_sync_bus;

  localparam int NDUT = 4;
  localparam int DEP [NDUT] = '{2, 2, 3, 2};
  localparam int FIL [NDUT] = '{1, 4, 3, 1};
  localparam logic [7:0] RV [NDUT] = '{8'h00, 8'h00, 8'h00, 8'hFF};

  logic            clock = 1'b0;
  logic [NDUT-1:0] rst;
  logic [7:0]      sin [NDUT];
  logic [7:0]      lvl [NDUT];
  logic [7:0]      rs  [NDUT];
  logic [7:0]      fl  [NDUT];
  logic [7:0]      ch  [NDUT];
  logic [NDUT-1:0] cha;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  sync_bus u_dut0 (
    .clock(clock), .reset(rst[0]), .sig_in(sin[0]), .level(lvl[0]),
    .rise(rs[0]), .fall(fl[0]), .change(ch[0]), .change_any(cha[0])
  );
  sync_bus #(.WIDTH(8), .DEPTH(2), .FILTER(4)) u_dut1 (
    .clock(clock), .reset(rst[1]), .sig_in(sin[1]), .level(lvl[1]),
    .rise(rs[1]), .fall(fl[1]), .change(ch[1]), .change_any(cha[1])
  );
  sync_bus #(.WIDTH(8), .DEPTH(3), .FILTER(3)) u_dut2 (
    .clock(clock), .reset(rst[2]), .sig_in(sin[2]), .level(lvl[2]),
    .rise(rs[2]), .fall(fl[2]), .change(ch[2]), .change_any(cha[2])
  );
  sync_bus #(.WIDTH(8), .DEPTH(2), .FILTER(1), .RESET_VAL(8'hFF)) u_dut3 (
    .clock(clock), .reset(rst[3]), .sig_in(sin[3]), .level(lvl[3]),
    .rise(rs[3]), .fall(fl[3]), .change(ch[3]), .change_any(cha[3])
  );

  // Reference model: sync is sig_in delayed DEPTH edges; a channel's level takes a
  // new value once FILTER consecutive sync samples of that value have been seen.
  logic [7:0] hist [NDUT][8];
  logic [7:0] m_lvl [NDUT];
  logic [7:0] m_rise [NDUT];
  logic [7:0] m_fall [NDUT];
  logic [7:0] m_last [NDUT];
  logic       m_any [NDUT];
  int         run [NDUT][8];
  bit         m_ok [NDUT] = '{0, 0, 0, 0};
  logic [7:0] m_sync, m_nxt;

  always @(posedge clock) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst[d]) begin
        for (int i = 0; i < 8; i++) begin
          hist[d][i] = RV[d];
          run[d][i]  = 0;
        end
        m_lvl[d]  = RV[d];
        m_last[d] = RV[d];
        m_rise[d] = 8'h00;
        m_fall[d] = 8'h00;
        m_any[d]  = 1'b0;
        m_ok[d]   = 1'b1;
      end else begin
        m_sync = hist[d][DEP[d]-1];
        for (int i = 7; i > 0; i--) if (i < DEP[d]) hist[d][i] = hist[d][i-1];
        hist[d][0] = sin[d];
        m_nxt = m_lvl[d];
        for (int b = 0; b < 8; b++) begin
          if (m_sync[b] == m_last[d][b]) run[d][b] = run[d][b] + 1;
          else                           run[d][b] = 1;
          if (m_sync[b] != m_lvl[d][b] && run[d][b] >= FIL[d]) m_nxt[b] = m_sync[b];
        end
        m_last[d] = m_sync;
        m_rise[d] = m_nxt & ~m_lvl[d];
        m_fall[d] = ~m_nxt & m_lvl[d];
        m_any[d]  = (m_nxt != m_lvl[d]);
        m_lvl[d]  = m_nxt;
      end
    end
  end

  bit         cnt_en = 0;
  int         strobe_cnt = 0;
  int         trans_cnt = 0;
  logic [7:0] prev_lvl2 = 8'h00;

  always @(negedge clock) begin
    for (int d = 0; d < NDUT; d++) begin
      if (m_ok[d]) begin
        vectors++;
        if (lvl[d] !== m_lvl[d] || rs[d] !== m_rise[d] || fl[d] !== m_fall[d] ||
            ch[d] !== (m_rise[d] | m_fall[d]) || cha[d] !== m_any[d]) begin
          miscompares++;
          $display("FAIL model dut%0d t=%0t: level %h/%h rise %h/%h fall %h/%h change %h/%h any %b/%b (got/exp)",
                   d, $time, lvl[d], m_lvl[d], rs[d], m_rise[d], fl[d], m_fall[d],
                   ch[d], m_rise[d] | m_fall[d], cha[d], m_any[d]);
        end
      end
    end
    if (cnt_en) begin
      strobe_cnt += $countones(rs[2] | fl[2]);
      trans_cnt  += $countones(lvl[2] ^ prev_lvl2);
    end
    prev_lvl2 = lvl[2];
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic [7:0] sig;
    logic [7:0] lvl;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       any;
  } vec_t;

  vec_t tbl [0:20];
  int   any_cnt;

  initial begin
    rst = '1;
    for (int d = 0; d < NDUT; d++) sin[d] = 8'h00;

    // Defaults: rise on edge 3, fall, reset mid-chain, back-to-back FILTER=1 toggles.
    tbl[0]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1};
    tbl[4]  = '{1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
    tbl[8]  = '{1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 8'h04, 8'h04, 8'h04, 8'h00, 1'b1};
    tbl[13] = '{1'b0, 8'h04, 8'h04, 8'h00, 8'h00, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 8'h04, 8'h00, 8'h00, 1'b0};
    tbl[15] = '{1'b0, 8'h04, 8'h04, 8'h00, 8'h00, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h04, 1'b1};
    tbl[17] = '{1'b0, 8'h04, 8'h04, 8'h04, 8'h00, 1'b1};
    tbl[18] = '{1'b0, 8'h04, 8'h00, 8'h00, 8'h04, 1'b1};
    tbl[19] = '{1'b0, 8'h04, 8'h04, 8'h04, 8'h00, 1'b1};
    tbl[20] = '{1'b0, 8'h04, 8'h04, 8'h00, 8'h00, 1'b0};

    repeat (2) @(negedge clock);

    for (int i = 0; i <= 20; i++) begin
      rst[0] = tbl[i].rst;
      sin[0] = tbl[i].sig;
      @(negedge clock);
      chk($sformatf("tbl%0d level", i), lvl[0], tbl[i].lvl);
      chk($sformatf("tbl%0d rise", i), rs[0], tbl[i].rise);
      chk($sformatf("tbl%0d fall", i), fl[0], tbl[i].fall);
      chk($sformatf("tbl%0d change", i), ch[0], tbl[i].rise | tbl[i].fall);
      chk($sformatf("tbl%0d change_any", i), {7'd0, cha[0]}, {7'd0, tbl[i].any});
    end

    // FILTER=4: a 3-cycle pulse is swallowed, a held level is accepted on edge 6.
    rst[1] = 1'b0;
    repeat (3) @(negedge clock);
    sin[1] = 8'h08;
    repeat (3) @(negedge clock);
    sin[1] = 8'h00;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      chk($sformatf("f4 glitch level n%0d", n), lvl[1], 8'h00);
      chk($sformatf("f4 glitch rise n%0d", n), rs[1], 8'h00);
    end
    sin[1] = 8'h08;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      chk($sformatf("f4 hold level n%0d", n), lvl[1], (n >= 6) ? 8'h08 : 8'h00);
      chk($sformatf("f4 hold rise n%0d", n), rs[1], (n == 6) ? 8'h08 : 8'h00);
    end

    // RESET_VAL=FF released with all inputs low: one group of falls on edge 3.
    any_cnt = 0;
    rst[3] = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      if (cha[3] === 1'b1) any_cnt++;
      chk($sformatf("rv level n%0d", n), lvl[3], (n >= 3) ? 8'h00 : 8'hFF);
      chk($sformatf("rv fall n%0d", n), fl[3], (n == 3) ? 8'hFF : 8'h00);
      chk($sformatf("rv rise n%0d", n), rs[3], 8'h00);
    end
    chk("rv change_any pulses", 8'(any_cnt), 8'd1);

    // Random inputs with sticky bits so that both glitches and long runs occur.
    rst[2] = 1'b0;
    repeat (4) @(negedge clock);
    cnt_en = 1;
    for (int c = 0; c < 10000; c++) begin
      logic [7:0] flip;
      flip = 8'h00;
      for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(3) == 0);
      sin[2] = sin[2] ^ flip;
      @(negedge clock);
    end
    cnt_en = 0;
    chk("random strobes vs transitions lo", 8'(strobe_cnt), 8'(trans_cnt));
    chk("random strobes vs transitions hi", 8'(strobe_cnt >> 8), 8'(trans_cnt >> 8));
    chk("random activity seen", {7'd0, trans_cnt > 100}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_bus.md
# sync_bus

Multi-channel successor to the single-bit level and pulse synchronizers. It brings WIDTH asynchronous control or status bits into the `clock` domain through a configurable-depth flop chain, then applies an optional per-channel stability filter (deglitch). Each channel provides a filtered level plus one-cycle rise, fall and change strobes. It sits at the boundary between external or foreign-domain signals (PTT, key, ADC overload, status flags) and the FPGA control logic.

## Interface
- WIDTH, 8, number of independent channels
- DEPTH, 2, synchronizer flops per channel; legal ≥2
- FILTER, 1, consecutive synchronized samples a new value must hold before `level` accepts it; legal ≥1; 1 = no filtering
- RESET_VAL, {WIDTH{1'b0}}, reset value of chain, `level` and `level_prev` state per channel
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- sig_in  in  WIDTH  asynchronous inputs, one per channel
- level  out  WIDTH  synchronized, filtered level
- rise  out  WIDTH  1-cycle strobe: channel's `level` went 0→1
- fall  out  WIDTH  1-cycle strobe: channel's `level` went 1→0
- change  out  WIDTH  rise | fall
- change_any  out  1  OR-reduction of `change`, registered (same cycle as `change`)

## Operation
- Per channel, independent, no cross-channel coherence guaranteed (not a bus synchronizer for multi-bit values).
- Stage 1: DEPTH-flop shift chain, sig_in enters chain[DEPTH-1], sync output = chain[0]; chain flops must carry a preserve/keep attribute so synthesis neither merges nor retimes them.
- Stage 2 filter: counter cnt, width clog2(FILTER+1).
  - sync == level → cnt <= 0.
  - sync != level and cnt == FILTER-1 → level <= sync, cnt <= 0.
  - else → cnt <= cnt+1.
  - FILTER=1: level follows sync with one register delay; cnt is constant 0 (may be optimised away).
- Glitch rule: differing run shorter than FILTER samples → cnt cleared on the first matching sample, level unchanged, no strobe.
- Strobes registered: on the edge where level updates, rise/fall/change are set for exactly that one following cycle, coincident with the first cycle of the new level. Never asserted for two consecutive cycles on a channel (level cannot toggle faster than every FILTER cycles; for FILTER=1 back-to-back toggles give back-to-back single strobes of alternating type).
- rise and fall are never both high on one channel.
- Reset (any time): chain and level = RESET_VAL; cnt = 0; rise/fall/change/change_any = 0. In-flight transitions are discarded. No strobe on the reset-release cycle. If sig_in differs from RESET_VAL at release, it propagates normally and yields one strobe after full latency.

## Timing
- Counting the first edge that captures a new stable sig_in value as edge 1: level, rise/fall/change and change_any update on edge DEPTH+FILTER.
- Defaults (DEPTH=2, FILTER=1): 3 edges.
- Minimum sig_in pulse guaranteed to be seen: FILTER+1 clock periods (metastability margin). Shorter pulses may be lost.
- Outputs are all direct flop outputs; no combinational path from sig_in to any output.

## Structure
- Sub-module `sync_bus_ch`: one channel (chain, filter counter, level, strobes), instantiated WIDTH times in a generate loop. Top adds change_any register.
- Counter-width clog2 function lives in the shared constants/functions include used across the gateware; no new typedefs required.

## Test plan
- Defaults, reset released, sig_in[0] 0→1 held → level[0]=1 and rise[0]=1 (one cycle) on edge 3; change_any=1 same cycle; other channels quiet.
- FILTER=4, DEPTH=2: sig_in[3] high for 3 cycles then low → no level change, no strobe; held high 6 cycles → level[3] rises on edge 6, single rise[3].
- FILTER=1: sig_in[1] toggles every 2 cycles → level[1] follows with a 3-edge lag, alternating single-cycle rise/fall strobes, never both high.
- RESET_VAL=8'hFF, sig_in=8'h00 at reset release → no strobe on release cycle; all eight fall strobes together on edge 3, change_any=1 once.
- Reset asserted 1 cycle after sig_in[2] rises (mid-chain) → all outputs RESET_VAL/0 next cycle; after release, rise[2] on edge 3 counted from release, exactly one strobe.
- Random async sig_in over 10k cycles, FILTER=3 → scoreboard model: every level change preceded by ≥3 matching sync samples; strobe count equals level transition count.
